serial_adder_ctrl: RTL

//   Bit-serial add controller: time-shares ONE full_adder cell to compute an
//   N-bit sum A + B + Cin, one bit per clock, LSB first. Owns operand shift

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller: FSM state codes
// used by the RTL and by anything that monitors the debug state output.
package serial_add_pkg;

    // 2'd3 is not a legal code; the FSM steers it back to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the only arithmetic cell in the serial add datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: computes A + B + Cin one bit per clock, LSB
// first, by time-sharing a single full_adder cell.
//
// Handshake: start is sampled only while idle (busy=0); the accepting edge
// captures a_in/b_in/cin_in. busy stays high from the cycle after acceptance
// through the done cycle. done is a one-cycle pulse, WIDTH cycles after the
// accepting edge, in the same cycle that sum_out/carry_out first show the new
// result. start while busy is ignored (not queued); a held start is
// re-accepted on the first idle cycle.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic [1:0]       state_dbg
);

    // One extra counter bit keeps WIDTH=1 legal.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] r_sh_q;
    logic [WIDTH-1:0] r_sh_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum;
    logic             fa_carry;

    full_adder FA (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign r_sh_d = WIDTH'({fa_sum, r_sh_q} >> 1);

    // Control FSM with registered busy/done that track the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == LAST_BIT) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture, serial shifting, carry feedback and result update.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q <= a_in;
                        b_sh_q <= b_in;
                        c_q    <= cin_in;
                        cnt_q  <= '0;
                        r_sh_q <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    c_q    <= fa_carry;
                    r_sh_q <= r_sh_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= r_sh_d;
                        carry_q <= fa_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_out   = sum_q;
    assign carry_out = carry_q;
    assign state_dbg = state_q;

endmodule
